// File: rtl/jpeg_pkg.sv
// jpeg_pkg
// Shared definitions for the JPEG entropy path: component encodings,
// the largest DC size category, and the field widths used by the DC
// Huffman tables and the extra-bits path.
package jpeg_pkg;

   typedef enum logic [1:0] {
      COMP_Y   = 2'd0,
      COMP_CB  = 2'd1,
      COMP_CR  = 2'd2,
      COMP_BAD = 2'd3
   } comp_e;

   localparam int DC_MAX_CAT = 11;
   localparam int DIFF_W     = 12;
   localparam int CODE_W     = 16;
   localparam int LEN_W      = 5;
   localparam int BITS_W     = 11;
   localparam int NBITS_W    = 4;

endpackage

// File: rtl/dc_huff_chroma.sv
// dc_huff_chroma
// Standard chrominance DC Huffman table (size category -> code, length).
// Ports:
//   i_size - size category 0..11
//   o_code - Huffman code, right-aligned
//   o_len  - code length in bits (0 for out-of-range sizes)
module dc_huff_chroma
   import jpeg_pkg::*;
(
   input  logic [NBITS_W-1:0] i_size,
   output logic [CODE_W-1:0]  o_code,
   output logic [LEN_W-1:0]   o_len
);

   // Sizes 4..11 are size-1 ones followed by a zero, with length = size.
   always_comb begin
      o_code = '0;
      o_len  = '0;
      case (i_size)
         4'd0:  begin o_code = 16'h0000; o_len = 5'd2;  end
         4'd1:  begin o_code = 16'h0001; o_len = 5'd2;  end
         4'd2:  begin o_code = 16'h0002; o_len = 5'd2;  end
         4'd3:  begin o_code = 16'h0006; o_len = 5'd3;  end
         4'd4:  begin o_code = 16'h000E; o_len = 5'd4;  end
         4'd5:  begin o_code = 16'h001E; o_len = 5'd5;  end
         4'd6:  begin o_code = 16'h003E; o_len = 5'd6;  end
         4'd7:  begin o_code = 16'h007E; o_len = 5'd7;  end
         4'd8:  begin o_code = 16'h00FE; o_len = 5'd8;  end
         4'd9:  begin o_code = 16'h01FE; o_len = 5'd9;  end
         4'd10: begin o_code = 16'h03FE; o_len = 5'd10; end
         4'd11: begin o_code = 16'h07FE; o_len = 5'd11; end
         default: begin o_code = '0; o_len = '0; end
      endcase
   end

endmodule

// File: rtl/dc_huff_luma.sv
// dc_huff_luma
// Standard luminance DC Huffman table (size category -> code, length).
// Ports:
//   i_size - size category 0..11
//   o_code - Huffman code, right-aligned
//   o_len  - code length in bits (0 for out-of-range sizes)
module dc_huff_luma
   import jpeg_pkg::*;
(
   input  logic [NBITS_W-1:0] i_size,
   output logic [CODE_W-1:0]  o_code,
   output logic [LEN_W-1:0]   o_len
);

   // Straight table lookup; sizes above 11 cannot occur and map to zero.
   always_comb begin
      o_code = '0;
      o_len  = '0;
      case (i_size)
         4'd0:  begin o_code = 16'h0000; o_len = 5'd2; end
         4'd1:  begin o_code = 16'h0002; o_len = 5'd3; end
         4'd2:  begin o_code = 16'h0003; o_len = 5'd3; end
         4'd3:  begin o_code = 16'h0004; o_len = 5'd3; end
         4'd4:  begin o_code = 16'h0005; o_len = 5'd3; end
         4'd5:  begin o_code = 16'h0006; o_len = 5'd3; end
         4'd6:  begin o_code = 16'h000E; o_len = 5'd4; end
         4'd7:  begin o_code = 16'h001E; o_len = 5'd5; end
         4'd8:  begin o_code = 16'h003E; o_len = 5'd6; end
         4'd9:  begin o_code = 16'h007E; o_len = 5'd7; end
         4'd10: begin o_code = 16'h00FE; o_len = 5'd8; end
         4'd11: begin o_code = 16'h01FE; o_len = 5'd9; end
         default: begin o_code = '0; o_len = '0; end
      endcase
   end

endmodule

// File: rtl/dc_size_cat.sv
// dc_size_cat
// Combinational size-category and extra-bits former for a DC difference.
// Ports:
//   i_diff  - signed 12-bit DC difference (-2047..2047)
//   o_size  - bit length of |i_diff| (0..11)
//   o_bits  - extra bits, right-aligned, zero above o_size
module dc_size_cat
   import jpeg_pkg::*;
(
   input  logic signed [DIFF_W-1:0]  i_diff,
   output logic        [NBITS_W-1:0] o_size,
   output logic        [BITS_W-1:0]  o_bits
);

   logic [DIFF_W-1:0] w_mag;
   logic [BITS_W-1:0] w_raw;
   logic [BITS_W-1:0] w_mask;

   // Negative differences are sent as the one's complement of their
   // magnitude, which in the low bits equals diff-1; only the low 11 bits
   // can ever survive the mask, so the subtraction is done at that width.
   always_comb begin
      w_mag  = i_diff[DIFF_W-1] ? (~i_diff + 12'd1) : i_diff;
      w_raw  = i_diff[DIFF_W-1] ? (i_diff[BITS_W-1:0] - 11'd1) : i_diff[BITS_W-1:0];
      o_size = '0;
      for (int i = 0; i < DIFF_W; i++) begin
         if (w_mag[i]) begin
            o_size = NBITS_W'(i + 1);
         end
      end
      // A shift by 11 wraps to zero in 11 bits, so the mask becomes all ones.
      w_mask = (11'd1 << o_size) - 11'd1;
      o_bits = w_raw & w_mask;
   end

endmodule

// File: rtl/dc_diff_encoder.sv
// dc_diff_encoder
// JPEG baseline DC coder: per-component DPCM prediction, size category,
// luma/chroma DC Huffman lookup, two-stage valid/ready pipeline.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   dc_vld/dc_rdy                 - input handshake
//   dc_coef, dc_comp, dc_rst_pred - coefficient, component, restart flag
//   out_vld/out_rdy               - output handshake
//   out_code/out_len              - Huffman code and its length
//   out_bits/out_nbits            - extra bits and their count
//   out_comp, out_err             - component tag, illegal-component flag
//   tot_bits                      - saturating count of emitted bits
module dc_diff_encoder
   import jpeg_pkg::*;
#(
   parameter int COEF_W = 11
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dc_vld,
   output logic                     dc_rdy,
   input  logic signed [COEF_W-1:0] dc_coef,
   input  logic [1:0]               dc_comp,
   input  logic                     dc_rst_pred,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [CODE_W-1:0]        out_code,
   output logic [LEN_W-1:0]         out_len,
   output logic [BITS_W-1:0]        out_bits,
   output logic [NBITS_W-1:0]       out_nbits,
   output logic [1:0]               out_comp,
   output logic                     out_err,
   output logic [23:0]              tot_bits
);

   logic                     w_en;
   logic                     w_accept;
   logic                     w_compOk;
   logic signed [COEF_W-1:0] w_pred;
   logic signed [DIFF_W-1:0] w_diff;
   logic [NBITS_W-1:0]       w_size;
   logic [BITS_W-1:0]        w_bits;
   logic [CODE_W-1:0]        w_lumaCode, w_chromaCode;
   logic [LEN_W-1:0]         w_lumaLen, w_chromaLen;
   logic [24:0]              w_totSum;

   logic signed [COEF_W-1:0] r_predY, r_predCb, r_predCr;
   logic                     r_s1Vld, r_s1Err;
   logic signed [DIFF_W-1:0] r_s1Diff;
   logic [1:0]               r_s1Comp;
   logic                     r_outVld, r_outErr;
   logic [CODE_W-1:0]        r_outCode;
   logic [LEN_W-1:0]         r_outLen;
   logic [BITS_W-1:0]        r_outBits;
   logic [NBITS_W-1:0]       r_outNbits;
   logic [1:0]               r_outComp;
   logic [23:0]              r_totBits;

   // The whole pipeline advances together whenever the output register is
   // empty or being drained; ready upstream is exactly that enable.
   assign w_en     = !r_outVld || out_rdy;
   assign dc_rdy   = w_en;
   assign w_accept = dc_vld && w_en;
   assign w_compOk = (dc_comp != COMP_BAD);

   // Predictor selection happens on the input side, so a same-component
   // beat directly behind another sees the freshly written value.
   always_comb begin
      w_pred = '0;
      if (!dc_rst_pred) begin
         case (dc_comp)
            COMP_Y:  w_pred = r_predY;
            COMP_CB: w_pred = r_predCb;
            COMP_CR: w_pred = r_predCr;
            default: w_pred = '0;
         endcase
      end
      w_diff = DIFF_W'(dc_coef) - DIFF_W'(w_pred);
   end

   // Restart clears all three predictors; the beat's own component (if
   // legal) then takes the new coefficient in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_predY  <= '0;
         r_predCb <= '0;
         r_predCr <= '0;
      end else if (w_accept) begin
         if (dc_rst_pred) begin
            r_predY  <= '0;
            r_predCb <= '0;
            r_predCr <= '0;
         end
         case (dc_comp)
            COMP_Y:  r_predY  <= dc_coef;
            COMP_CB: r_predCb <= dc_coef;
            COMP_CR: r_predCr <= dc_coef;
            default: ;
         endcase
      end
   end

   // Stage 1 holds the difference; an illegal beat carries a zero diff and
   // its error flag so it still occupies a slot in the stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Vld  <= 1'b0;
         r_s1Err  <= 1'b0;
         r_s1Diff <= '0;
         r_s1Comp <= '0;
      end else if (w_en) begin
         r_s1Vld  <= dc_vld;
         r_s1Err  <= dc_vld && !w_compOk;
         r_s1Diff <= w_compOk ? w_diff : '0;
         r_s1Comp <= dc_comp;
      end
   end

   dc_size_cat u_sizeCat (
      .i_diff (r_s1Diff),
      .o_size (w_size),
      .o_bits (w_bits)
   );

   dc_huff_luma u_lumaLut (
      .i_size (w_size),
      .o_code (w_lumaCode),
      .o_len  (w_lumaLen)
   );

   dc_huff_chroma u_chromaLut (
      .i_size (w_size),
      .o_code (w_chromaCode),
      .o_len  (w_chromaLen)
   );

   // Output stage: pick the table by component and blank every field of an
   // illegal beat, since the tables still return a code for size 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outVld   <= 1'b0;
         r_outErr   <= 1'b0;
         r_outCode  <= '0;
         r_outLen   <= '0;
         r_outBits  <= '0;
         r_outNbits <= '0;
         r_outComp  <= '0;
      end else if (w_en) begin
         r_outVld  <= r_s1Vld;
         r_outErr  <= r_s1Err;
         r_outComp <= r_s1Comp;
         if (r_s1Err) begin
            r_outCode  <= '0;
            r_outLen   <= '0;
            r_outBits  <= '0;
            r_outNbits <= '0;
         end else begin
            r_outCode  <= (r_s1Comp == COMP_Y) ? w_lumaCode : w_chromaCode;
            r_outLen   <= (r_s1Comp == COMP_Y) ? w_lumaLen  : w_chromaLen;
            r_outBits  <= w_bits;
            r_outNbits <= w_size;
         end
      end
   end

   // Running bit count, widened by one bit so overflow can be detected and
   // clamped rather than wrapping.
   assign w_totSum = {1'b0, r_totBits} + 25'(r_outLen) + 25'(r_outNbits);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_totBits <= '0;
      end else if (r_outVld && out_rdy && !r_outErr) begin
         r_totBits <= w_totSum[24] ? 24'hFFFFFF : w_totSum[23:0];
      end
   end

   assign out_vld   = r_outVld;
   assign out_err   = r_outErr;
   assign out_code  = r_outCode;
   assign out_len   = r_outLen;
   assign out_bits  = r_outBits;
   assign out_nbits = r_outNbits;
   assign out_comp  = r_outComp;
   assign tot_bits  = r_totBits;

endmodule

// File: tb/tb_dc_diff_encoder.sv
// tb_dc_diff_encoder
// Directed bench for dc_diff_encoder with hand-computed expected beats.
module tb_dc_diff_encoder;

   typedef struct packed {
      logic [15:0] code;
      logic [4:0]  len;
      logic [10:0] bits;
      logic [3:0]  nbits;
      logic [1:0]  comp;
      logic        err;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               dc_vld = 1'b0;
   logic               dc_rdy;
   logic signed [10:0] dc_coef = '0;
   logic [1:0]         dc_comp = '0;
   logic               dc_rst_pred = 1'b0;
   logic               out_vld;
   logic               out_rdy = 1'b1;
   logic [15:0]        out_code;
   logic [4:0]         out_len;
   logic [10:0]        out_bits;
   logic [3:0]         out_nbits;
   logic [1:0]         out_comp;
   logic               out_err;
   logic [23:0]        tot_bits;

   beat_t outQ[$];
   int    errorCount = 0;
   int    checkCount = 0;

   always #5 clk = ~clk;

   dc_diff_encoder #(.COEF_W(11)) dut (
      .clk         (clk),
      .rst         (rst),
      .dc_vld      (dc_vld),
      .dc_rdy      (dc_rdy),
      .dc_coef     (dc_coef),
      .dc_comp     (dc_comp),
      .dc_rst_pred (dc_rst_pred),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_code    (out_code),
      .out_len     (out_len),
      .out_bits    (out_bits),
      .out_nbits   (out_nbits),
      .out_comp    (out_comp),
      .out_err     (out_err),
      .tot_bits    (tot_bits)
   );

   // Capture every output beat that will handshake on the coming edge.
   always @(negedge clk) begin
      if (!rst && out_vld && out_rdy) begin
         outQ.push_back(beat_t'{out_code, out_len, out_bits, out_nbits, out_comp, out_err});
      end
   end

   function automatic beat_t mkBeat(input int code, input int len, input int bits,
                                    input int nbits, input int comp, input int err);
      beat_t b;
      b.code  = 16'(code);
      b.len   = 5'(len);
      b.bits  = 11'(bits);
      b.nbits = 4'(nbits);
      b.comp  = 2'(comp);
      b.err   = 1'(err);
      return b;
   endfunction

   task automatic doReset();
      rst = 1'b1;
      dc_vld = 1'b0;
      dc_coef = '0;
      dc_comp = '0;
      dc_rst_pred = 1'b0;
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      outQ.delete();
   endtask

   // Presents one beat and returns 1 time unit after the edge that took it.
   task automatic applyStimulus(input int coef, input int comp, input logic rstPred);
      logic rdySeen;
      bit   done;
      done = 0;
      dc_coef = 11'(coef);
      dc_comp = 2'(comp);
      dc_rst_pred = rstPred;
      dc_vld = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         rdySeen = dc_rdy;
         @(posedge clk);
         #1;
         done = rdySeen;
      end
      checkCount++;
      if (!done) begin
         errorCount++;
         $display("[TB] FAIL accept_timeout: beat coef=%0d comp=%0d not accepted, required acceptance within 50 cycles", coef, comp);
      end
   endtask

   task automatic goIdle();
      dc_vld = 1'b0;
      dc_rst_pred = 1'b0;
   endtask

   task automatic waitOutputs(input int n);
      for (int k = 0; k < 60 && outQ.size() < n; k++) begin
         @(posedge clk);
         #2;
      end
      checkCount++;
      if (outQ.size() < n) begin
         errorCount++;
         $display("[TB] FAIL output_timeout: got %0d beats, required %0d", outQ.size(), n);
      end
   endtask

   task automatic test_reset();
      doReset();
      checkCount++;
      if ({out_vld, out_err, out_code, out_len, out_bits, out_nbits, out_comp} !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_outputs: vld=%b err=%b code=%h len=%0d bits=%h nbits=%0d comp=%0d, required all 0",
                  out_vld, out_err, out_code, out_len, out_bits, out_nbits, out_comp);
      end
      checkCount++;
      if (tot_bits !== 24'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_tot_bits: got %0d required 0", tot_bits);
      end
      checkCount++;
      if (dc_rdy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_dc_rdy: got %b required 1", dc_rdy);
      end
   endtask

   task automatic test_latency();
      beat_t exp;
      doReset();
      applyStimulus(5, 0, 1'b0);
      goIdle();
      checkCount++;
      if (out_vld !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL latency_early: out_vld=%b one cycle after accept, required 0", out_vld);
      end
      @(posedge clk);
      #1;
      exp = mkBeat(16'h4, 3, 11'h5, 3, 0, 0);
      checkCount++;
      if (out_vld !== 1'b1 || beat_t'{out_code, out_len, out_bits, out_nbits, out_comp, out_err} !== exp) begin
         errorCount++;
         $display("[TB] FAIL latency_beat: vld=%b beat=%h, required vld=1 beat=%h", out_vld,
                  beat_t'{out_code, out_len, out_bits, out_nbits, out_comp, out_err}, exp);
      end
      waitOutputs(1);
      checkCount++;
      if (tot_bits !== 24'd6) begin
         errorCount++;
         $display("[TB] FAIL latency_tot_bits: got %0d required 6", tot_bits);
      end
   endtask

   task automatic test_same_comp();
      beat_t exp[2];
      beat_t got;
      exp[0] = mkBeat(16'h2, 2, 11'h0, 2, 1, 0);
      exp[1] = mkBeat(16'h0, 2, 11'h0, 0, 1, 0);
      doReset();
      applyStimulus(-3, 1, 1'b0);
      applyStimulus(-3, 1, 1'b0);
      goIdle();
      waitOutputs(2);
      for (int i = 0; i < 2; i++) begin
         got = (i < outQ.size()) ? outQ[i] : '0;
         checkCount++;
         if (got !== exp[i]) begin
            errorCount++;
            $display("[TB] FAIL same_comp_beat%0d: got %h required %h", i, got, exp[i]);
         end
      end
      @(posedge clk);
      #1;
      checkCount++;
      if (tot_bits !== 24'd6) begin
         errorCount++;
         $display("[TB] FAIL same_comp_tot_bits: got %0d required 6", tot_bits);
      end
   endtask

   task automatic test_extremes();
      beat_t exp[2];
      beat_t got;
      exp[0] = mkBeat(16'h1FE, 9, 11'h3FF, 11, 0, 0);
      exp[1] = mkBeat(16'h1FE, 9, 11'h7FF, 11, 0, 0);
      doReset();
      applyStimulus(-1024, 0, 1'b0);
      applyStimulus(1023, 0, 1'b0);
      goIdle();
      waitOutputs(2);
      for (int i = 0; i < 2; i++) begin
         got = (i < outQ.size()) ? outQ[i] : '0;
         checkCount++;
         if (got !== exp[i]) begin
            errorCount++;
            $display("[TB] FAIL extreme_beat%0d: got %h required %h", i, got, exp[i]);
         end
      end
      @(posedge clk);
      #1;
      checkCount++;
      if (tot_bits !== 24'd40) begin
         errorCount++;
         $display("[TB] FAIL extreme_tot_bits: got %0d required 40", tot_bits);
      end
   endtask

   task automatic test_restart();
      int    coefs[7] = '{10, 4, 2, 12, 7, 0, 1};
      int    comps[7] = '{0, 1, 2, 0, 2, 0, 1};
      beat_t exp[7];
      beat_t got;
      exp[0] = mkBeat(16'h5, 3, 11'hA, 4, 0, 0);
      exp[1] = mkBeat(16'h6, 3, 11'h4, 3, 1, 0);
      exp[2] = mkBeat(16'h2, 2, 11'h2, 2, 2, 0);
      exp[3] = mkBeat(16'h3, 3, 11'h2, 2, 0, 0);
      exp[4] = mkBeat(16'h6, 3, 11'h7, 3, 2, 0);
      exp[5] = mkBeat(16'h0, 2, 11'h0, 0, 0, 0);
      exp[6] = mkBeat(16'h1, 2, 11'h1, 1, 1, 0);
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(coefs[i], comps[i], (i == 4) ? 1'b1 : 1'b0);
      end
      goIdle();
      waitOutputs(7);
      for (int i = 0; i < 7; i++) begin
         got = (i < outQ.size()) ? outQ[i] : '0;
         checkCount++;
         if (got !== exp[i]) begin
            errorCount++;
            $display("[TB] FAIL restart_beat%0d: got %h required %h", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_back_pressure();
      int    coefs[4] = '{3, 7, -5, -2};
      int    comps[4] = '{0, 0, 1, 0};
      beat_t exp[4];
      beat_t got;
      int    idx;
      logic  rdySeen;
      exp[0] = mkBeat(16'h3, 3, 11'h3, 2, 0, 0);
      exp[1] = mkBeat(16'h4, 3, 11'h4, 3, 0, 0);
      exp[2] = mkBeat(16'h6, 3, 11'h2, 3, 1, 0);
      exp[3] = mkBeat(16'h5, 3, 11'h6, 4, 0, 0);
      doReset();
      out_rdy = 1'b0;
      idx = 0;
      dc_coef = 11'(coefs[0]);
      dc_comp = 2'(comps[0]);
      dc_vld = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         rdySeen = dc_rdy;
         if (cyc >= 2) begin
            got = beat_t'{out_code, out_len, out_bits, out_nbits, out_comp, out_err};
            checkCount++;
            if (out_vld !== 1'b1 || got !== exp[0]) begin
               errorCount++;
               $display("[TB] FAIL stall_hold_cyc%0d: vld=%b beat=%h required vld=1 beat=%h", cyc, out_vld, got, exp[0]);
            end
         end
         @(posedge clk);
         #1;
         if (rdySeen) begin
            idx++;
            if (idx < 4) begin
               dc_coef = 11'(coefs[idx]);
               dc_comp = 2'(comps[idx]);
            end
         end
      end
      checkCount++;
      if (idx !== 2) begin
         errorCount++;
         $display("[TB] FAIL stall_accept_count: got %0d beats accepted required 2", idx);
      end
      checkCount++;
      if (dc_rdy !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL stall_dc_rdy: got %b required 0", dc_rdy);
      end
      out_rdy = 1'b1;
      for (int i = idx; i < 4; i++) begin
         applyStimulus(coefs[i], comps[i], 1'b0);
      end
      goIdle();
      waitOutputs(4);
      for (int i = 0; i < 4; i++) begin
         got = (i < outQ.size()) ? outQ[i] : '0;
         checkCount++;
         if (got !== exp[i]) begin
            errorCount++;
            $display("[TB] FAIL stall_drain_beat%0d: got %h required %h", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_illegal_comp();
      int    coefs[5] = '{5, 100, 9, 50, 6};
      int    comps[5] = '{0, 3, 0, 3, 0};
      beat_t exp[5];
      beat_t got;
      exp[0] = mkBeat(16'h4, 3, 11'h5, 3, 0, 0);
      exp[1] = mkBeat(16'h0, 0, 11'h0, 0, 3, 1);
      exp[2] = mkBeat(16'h4, 3, 11'h4, 3, 0, 0);
      exp[3] = mkBeat(16'h0, 0, 11'h0, 0, 3, 1);
      exp[4] = mkBeat(16'h4, 3, 11'h6, 3, 0, 0);
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(coefs[i], comps[i], (i == 3) ? 1'b1 : 1'b0);
      end
      goIdle();
      waitOutputs(5);
      for (int i = 0; i < 5; i++) begin
         got = (i < outQ.size()) ? outQ[i] : '0;
         checkCount++;
         if (got !== exp[i]) begin
            errorCount++;
            $display("[TB] FAIL illegal_beat%0d: got %h required %h", i, got, exp[i]);
         end
      end
      @(posedge clk);
      #1;
      checkCount++;
      if (tot_bits !== 24'd18) begin
         errorCount++;
         $display("[TB] FAIL illegal_tot_bits: got %0d required 18", tot_bits);
      end
   endtask

   task automatic test_reset_midstream();
      beat_t exp;
      beat_t got;
      doReset();
      applyStimulus(20, 0, 1'b0);
      applyStimulus(30, 1, 1'b0);
      goIdle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkCount++;
      if (out_vld !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL midreset_out_vld: got %b required 0", out_vld);
      end
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkCount++;
      if (outQ.size() !== 0 || out_vld !== 1'b0 || tot_bits !== 24'd0) begin
         errorCount++;
         $display("[TB] FAIL midreset_stale: beats=%0d vld=%b tot=%0d required 0 0 0", outQ.size(), out_vld, tot_bits);
      end
      exp = mkBeat(16'h6, 3, 11'h14, 5, 0, 0);
      applyStimulus(20, 0, 1'b0);
      goIdle();
      waitOutputs(1);
      got = (outQ.size() > 0) ? outQ[0] : '0;
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL midreset_pred_cleared: got %h required %h", got, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence; each task resets the design before its stimulus.
   initial begin
      test_reset();
      test_latency();
      test_same_comp();
      test_extremes();
      test_restart();
      test_back_pressure();
      test_illegal_comp();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dc_diff_encoder.md
# dc_diff_encoder

Sequencing controller for JPEG baseline DC coding: accepts one quantized DC coefficient per 8x8 block, tagged with its component, and keeps one DPCM predictor per component (Y/Cb/Cr). It forms the difference and size category, steers the lookup to the luma or chroma DC Huffman table, and emits the Huffman code plus extra bits over a valid/ready stream. It sits between the quantizer/zigzag stage and the entropy bit packer, alongside the AC run-length path.

## Interface
- `COEF_W`, default 11: signed DC coefficient width (range -1024..1023).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dc_vld`  in  1  input beat valid.
- `dc_rdy`  out  1  input beat ready.
- `dc_coef`  in  COEF_W  signed quantized DC coefficient.
- `dc_comp`  in  2  component: 0=Y, 1=Cb, 2=Cr, 3=illegal.
- `dc_rst_pred`  in  1  restart: clear all three predictors before this beat is used.
- `out_vld`  out  1  output beat valid.
- `out_rdy`  in  1  output beat ready.
- `out_code`  out  16  Huffman code, right-aligned.
- `out_len`  out  5  Huffman code length.
- `out_bits`  out  11  extra bits, right-aligned.
- `out_nbits`  out  4  extra bit count = size category.
- `out_comp`  out  2  component of this beat.
- `out_err`  out  1  beat carried `dc_comp`=3.
- `tot_bits`  out  24  running count of emitted bits (`out_len`+`out_nbits`), saturates at 0xFFFFFF.

## Operation
- A handshake occurs when `dc_vld`&&`dc_rdy`. Same rule on the output side.
- Stage 1 (accept):
  - p = `dc_rst_pred` ? 0 : pred[comp].
  - diff = coef − p, computed as a 12-bit signed value; the range is -2047..2047.
  - pred[comp] ← coef.
  - If `dc_rst_pred`=1, the other two predictors are also cleared to 0.
- Stage 2 (encode):
  - size = bit length of |diff|; size is 0 when diff=0, and the maximum is 11.
  - Extra bits: bits = diff when diff≥0, else (diff−1); keep the low `size` bits and zero the rest.
  - Table select: comp 0 uses the luma DC table; comp 1 and 2 use the chroma DC table. The result is registered into the output stage.
- Luma table, std K.3, as (size: code/len):
  - 0:00/2, 1:010/3, 2:011/3, 3:100/3, 4:101/3, 5:110/3.
  - 6:1110/4, 7:11110/5, 8:111110/6, 9:1111110/7, 10:11111110/8, 11:111111110/9.
- Chroma table, std K.4, as (size: code/len):
  - 0:00/2, 1:01/2, 2:10/2, 3:110/3.
  - 4 through 11: size−1 ones followed by a 0, with len = size.
- `dc_comp`=3:
  - Beat passes through the pipeline with `out_err`=1.
  - `out_code`, `out_len`, `out_bits` and `out_nbits` are all 0.
  - No predictor is updated, but `dc_rst_pred` is still honored.
  - `tot_bits` is not incremented.
- `tot_bits` increments by `out_len`+`out_nbits` on each output handshake.

## Timing
- Two register stages (s1, out). Pipeline enable is en = !`out_vld` || `out_rdy`.
- `dc_rdy` = en, combinational from `out_vld`/`out_rdy` only. It never depends on `dc_vld`.
- Latency: a beat accepted in cycle N presents `out_vld`=1 in cycle N+2, provided there is no stall.
- Throughput is 1 beat/cycle.
- Back-pressure: while `out_vld`&&!`out_rdy`:
  - All stages hold.
  - Output fields are stable.
  - Predictors do not change.
- A bubble in s1 does not block the output stage from draining.
- Reset values:
  - `out_vld`=0, `out_err`=0, all code/bit/len fields 0, `out_comp`=0.
  - `tot_bits`=0, predictors 0, s1 valid 0.
  - `dc_rdy` is 1 in the first cycle after reset.
- Reset mid-stream drops every in-flight beat and clears all state. No beat emerges after reset.
- Same-component back-to-back beats: the second beat's diff uses the first beat's coef. Predictor write and read are resolved in stage 1, so there is no hazard.
- `tot_bits` saturates and does not wrap.

## Structure
- A shared package `jpeg_pkg` holds:
  - `COMP_Y`/`COMP_CB`/`COMP_CR` encodings.
  - Maximum DC category (11).
  - Field widths for code/len/bits.
- Sub-module `dc_size_cat` is combinational: diff in → size, extra bits out.
- The luma and chroma DC Huffman LUT modules are instantiated unchanged. Both are driven by the same size, and the output is muxed by comp.

## Test plan
- After reset, beat Y coef=5 → out in 2 cycles: code=0x4, len=3, bits=0x5, nbits=3. `tot_bits`=6.
- Beat Cb coef=-3, then Cb coef=-3:
  - First output: code=0x2, len=2, bits=0x0, nbits=2.
  - Second output: code=0x0, len=2, nbits=0.
- Beat Y coef=-1024, then Y coef=1023 → second output: code=0x1FE, len=9, bits=0x7FF, nbits=11.
- Interleaved Y/Cb/Cr beats, then a beat with `dc_rst_pred`=1 on Cr coef=7:
  - The Cr beat codes diff=7 (chroma code=0x6, len=3, bits=0x7).
  - The next Y coef=0 codes diff=0.
- Hold `out_rdy`=0 for 5 cycles with 4 beats offered:
  - Exactly 2 beats are accepted, then `dc_rdy`=0.
  - Outputs stay stable.
  - On release, all 4 beats emerge in order with correct diffs.
- `dc_comp`=3 beat between two Y beats → `out_err`=1 with zero fields. The Y predictor chain is unaffected and `tot_bits` is unchanged. Assert `rst` while 2 beats are in flight → `out_vld`=0 and no stale output appears.
